cmd_cfg_mc: RTL and testbench

- Parametrised successor to the logic-analyser command/config block; sits between the UART wrapper (cmd, cmd_rdy, resp, send_resp, resp_sent) and NUM_CH capture RAM queues.
- Decodes 16-bit host commands: register read, register write and channel dump.
- Generalised to any channel count and register-file size, with circular-buffer dumps starting at the oldest sample.
- Explicit NAK responses for illegal commands.

---
 rtl/cmd_cfg_mc_if.sv | 14 +
 rtl/cmd_cfg_mc.sv | 170 +++++++++++++++++
 tb/tb_cmd_cfg_mc.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_cfg_mc_if.sv
`default_nettype none
// cmd_cfg_mc_if (rev 1.0): UART-side command/response handshake bundle for cmd_cfg_mc.
interface cmd_cfg_mc_if;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        resp_sent;
  logic        cmd_done;

  modport master (output cmd, cmd_rdy, resp_sent, input resp, send_resp, cmd_done);
  modport slave  (input cmd, cmd_rdy, resp_sent, output resp, send_resp, cmd_done);
endinterface
`default_nettype wire

// File: rtl/cmd_cfg_mc.sv
`default_nettype none
// cmd_cfg_mc (rev 1.0): host command decoder, config register file and circular channel dump.
// Optional macro CMD_DUMP_LEN_EN: non-zero cmd[7:0] on a dump limits the byte count.
module cmd_cfg_mc #(
  parameter int unsigned NUM_CH   = 5,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned ENTRIES  = 384,
  parameter int unsigned LOG2     = 9,
  parameter logic [7:0]  ACK      = 8'hA5,
  parameter logic [7:0]  NAK      = 8'hEE
) (
  input  logic                  clk,
  input  logic                  clr_cmd_rdy,
  cmd_cfg_mc_if.slave           uart,
  input  logic                  set_capture_done,
  input  logic [LOG2-1:0]       ram_addr,
  input  logic [NUM_CH*8-1:0]   rdata,
  output logic [NUM_REGS*8-1:0] regs,
  output logic [LOG2-1:0]       addr_ptr,
  output logic                  busy
);
  localparam logic [6:0]      C_NUM_REGS = 7'(NUM_REGS);
  localparam logic [2:0]      C_NUM_CH   = 3'(NUM_CH);
  localparam logic [LOG2-1:0] C_LAST     = LOG2'(ENTRIES - 1);
  localparam int unsigned     C_LENW     = (LOG2 + 1 > 8) ? LOG2 + 1 : 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RESP_WAIT = 3'd1,
    S_DUMP_RD   = 3'd2,
    S_DUMP_SEND = 3'd3,
    S_DUMP_WAIT = 3'd4
  } state_t;

  state_t                r_state, w_state;
  logic [NUM_REGS*8-1:0] r_regs, w_regs;
  logic [7:0]            r_resp, w_resp;
  logic                  r_send, w_send;
  logic                  r_done, w_done;
  logic                  r_armed, w_armed;
  logic [LOG2-1:0]       r_addr, w_addr;
  logic [LOG2-1:0]       r_cnt, w_cnt;
  logic [LOG2-1:0]       r_last, w_last;
  logic [LOG2-1:0]       w_len_m1;
  logic [2:0]            r_ch, w_ch;
  logic [7:0]            w_rd_byte, w_ram_byte;
  logic                  w_reg_ok, w_dump_ok;

  always_comb begin
    w_reg_ok  = {1'b0, uart.cmd[13:8]} < C_NUM_REGS;
    w_dump_ok = (uart.cmd[13:11] == 3'd0) && (uart.cmd[10:8] != 3'd0) &&
                (uart.cmd[10:8] <= C_NUM_CH);
    w_rd_byte = 8'h00;
    for (int k = 0; k < NUM_REGS; k++)
      if (uart.cmd[13:8] == 6'(k)) w_rd_byte = r_regs[8*k +: 8];
    w_ram_byte = 8'h00;
    for (int n = 1; n <= NUM_CH; n++)
      if (r_ch == 3'(n)) w_ram_byte = rdata[8*n-8 +: 8];
  end

`ifdef CMD_DUMP_LEN_EN
  logic [C_LENW-1:0] w_req;
  always_comb begin
    w_req = C_LENW'(uart.cmd[7:0]);
    if (w_req == '0 || w_req > C_LENW'(ENTRIES)) w_len_m1 = C_LAST;
    else                                         w_len_m1 = LOG2'(w_req - 1'b1);
  end
`else
  assign w_len_m1 = C_LAST;
`endif

  always_comb begin
    w_state = r_state;
    w_regs  = r_regs;
    w_resp  = r_resp;
    w_send  = 1'b0;
    w_done  = 1'b0;
    w_armed = r_armed | ~uart.cmd_rdy;
    w_addr  = r_addr;
    w_cnt   = r_cnt;
    w_last  = r_last;
    w_ch    = r_ch;
    case (r_state)
      S_IDLE: begin
        // A command still asserted after cmd_done must drop once before it is decoded again.
        if (uart.cmd_rdy && r_armed) begin
          w_armed = 1'b0;
          w_send  = 1'b1;
          w_resp  = NAK;
          w_state = S_RESP_WAIT;
          case (uart.cmd[15:14])
            2'b00: if (w_reg_ok) w_resp = w_rd_byte;
            2'b01: if (w_reg_ok) begin
              w_resp = ACK;
              for (int k = 0; k < NUM_REGS; k++)
                if (uart.cmd[13:8] == 6'(k)) w_regs[8*k +: 8] = uart.cmd[7:0];
            end
            2'b10: if (w_dump_ok) begin
              w_send  = 1'b0;
              w_resp  = r_resp;
              w_state = S_DUMP_RD;
              w_addr  = ram_addr;
              w_cnt   = '0;
              w_last  = w_len_m1;
              w_ch    = uart.cmd[10:8];
            end
            default: ;
          endcase
        end
      end
      S_RESP_WAIT: if (uart.resp_sent) begin
        w_done  = 1'b1;
        w_state = S_IDLE;
      end
      S_DUMP_RD:   w_state = S_DUMP_SEND;
      S_DUMP_SEND: begin
        w_resp  = w_ram_byte;
        w_send  = 1'b1;
        w_state = S_DUMP_WAIT;
      end
      S_DUMP_WAIT: if (uart.resp_sent) begin
        if (r_cnt == r_last) begin
          w_done  = 1'b1;
          w_state = S_IDLE;
        end else begin
          w_cnt   = r_cnt + 1'b1;
          w_addr  = (r_addr == C_LAST) ? '0 : r_addr + 1'b1;
          w_state = S_DUMP_RD;
        end
      end
      default: w_state = S_IDLE;
    endcase
    // Capture-done wins over a same-cycle write to reg 0.
    if (set_capture_done) w_regs[5] = 1'b1;
  end

  always_ff @(posedge clk or posedge clr_cmd_rdy) begin
    if (clr_cmd_rdy) begin
      r_state <= S_IDLE;
      r_regs  <= '0;
      r_resp  <= 8'h00;
      r_send  <= 1'b0;
      r_done  <= 1'b0;
      r_armed <= 1'b1;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_last  <= '0;
      r_ch    <= 3'd0;
    end else begin
      r_state <= w_state;
      r_regs  <= w_regs;
      r_resp  <= w_resp;
      r_send  <= w_send;
      r_done  <= w_done;
      r_armed <= w_armed;
      r_addr  <= w_addr;
      r_cnt   <= w_cnt;
      r_last  <= w_last;
      r_ch    <= w_ch;
    end
  end

  assign uart.resp      = r_resp;
  assign uart.send_resp = r_send;
  assign uart.cmd_done  = r_done;
  assign regs           = r_regs;
  assign addr_ptr       = r_addr;
  assign busy           = (r_state != S_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_cmd_cfg_mc.sv
`default_nettype none
// tb_cmd_cfg_mc (rev 1.0): randomized and directed bench for cmd_cfg_mc against a queue-based model.
module tb_cmd_cfg_mc;
  localparam int NUM_CH = 5, NUM_REGS = 16, ENTRIES = 384, LOG2 = 9;

  logic                  clk = 1'b0;
  logic                  clr_cmd_rdy = 1'b0;
  logic                  set_capture_done = 1'b0;
  logic [LOG2-1:0]       ram_addr = '0;
  logic [NUM_CH*8-1:0]   rdata = '0;
  logic [NUM_REGS*8-1:0] regs;
  logic [LOG2-1:0]       addr_ptr;
  logic                  busy;

  cmd_cfg_mc_if u_if ();

  cmd_cfg_mc #(.NUM_CH(NUM_CH), .NUM_REGS(NUM_REGS), .ENTRIES(ENTRIES), .LOG2(LOG2)) dut (
    .clk(clk), .clr_cmd_rdy(clr_cmd_rdy), .uart(u_if), .set_capture_done(set_capture_done),
    .ram_addr(ram_addr), .rdata(rdata), .regs(regs), .addr_ptr(addr_ptr), .busy(busy));

  always #5 clk = ~clk;

  logic [7:0] mem [1:NUM_CH][0:ENTRIES-1];
  logic [7:0] mregs [NUM_REGS];
  logic [7:0] exp_d [$];
  int         exp_a [$];
  logic [7:0] got_d [$];
  int         got_a [$];
  int         n_cmp = 0, n_fail = 0;
  logic       prev_rs = 1'b0;

  // Synchronous-read capture RAMs.
  always @(posedge clk)
    for (int n = 1; n <= NUM_CH; n++)
      rdata[8*n-8 +: 8] <= (addr_ptr < ENTRIES) ? mem[n][addr_ptr] : 8'h00;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NUM_REGS*8-1:0] flat();
    logic [NUM_REGS*8-1:0] f;
    for (int k = 0; k < NUM_REGS; k++) f[8*k +: 8] = mregs[k];
    return f;
  endfunction

  function automatic int dump_len(input logic [7:0] d);
`ifdef CMD_DUMP_LEN_EN
    if (d == 8'd0) return ENTRIES;
    return (int'(d) < ENTRIES) ? int'(d) : ENTRIES;
`else
    return ENTRIES + 0 * int'(d);
`endif
  endfunction

  function automatic logic [7:0] got_at(input int i);
    if (i < got_d.size()) return got_d[i];
    return 8'hxx;
  endfunction

  function automatic int gota_at(input int i);
    if (i < got_a.size()) return got_a[i];
    return -1;
  endfunction

  // Model: what bytes a command must produce, and its register side effects.
  task automatic model_cmd(input logic [15:0] c, input logic [LOG2-1:0] ra, input bit cap,
                           output int lat);
    logic [1:0] op;
    int a, ch;
    bit dump_ok;
    op = c[15:14];
    a  = int'(c[13:8]);
    ch = int'(c[10:8]);
    dump_ok = (op == 2'b10) && (c[13:11] == 3'd0) && (ch >= 1) && (ch <= NUM_CH);
    if (dump_ok) begin
      lat = 3;
      for (int k = 0; k < dump_len(c[7:0]); k++) begin
        exp_d.push_back(mem[ch][(int'(ra) + k) % ENTRIES]);
        exp_a.push_back((int'(ra) + k) % ENTRIES);
      end
    end else begin
      lat = 1;
      exp_a.push_back(-1);
      if (op == 2'b00 && a < NUM_REGS) exp_d.push_back(mregs[a]);
      else if (op == 2'b01 && a < NUM_REGS) begin
        exp_d.push_back(8'hA5);
        mregs[a] = c[7:0];
      end else exp_d.push_back(8'hEE);
    end
    if (cap) mregs[0][5] = 1'b1;
  endtask

  task automatic model_reset();
    exp_d.delete();
    exp_a.delete();
    for (int k = 0; k < NUM_REGS; k++) mregs[k] = 8'h00;
  endtask

  task automatic do_cmd(input logic [15:0] c, input logic [LOG2-1:0] ra, input bit cap);
    int lat, k, n;
    @(posedge clk);
    #1;
    u_if.cmd = c; ram_addr = ra; u_if.cmd_rdy = 1'b1; set_capture_done = cap;
    got_d.delete(); got_a.delete();
    @(posedge clk);
    model_cmd(c, ra, cap, lat);
    #1 set_capture_done = 1'b0;
    k = 99;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (u_if.send_resp) begin k = i; break; end
    end
    chk("first_send_latency", k, lat);
    n = 0;
    while (!u_if.cmd_done && n < ENTRIES * 8 + 40) begin @(negedge clk); n++; end
    chk("cmd_done_seen", u_if.cmd_done, 1'b1);
    chk("idle_at_done", busy, 1'b0);
    @(posedge clk);
    #1 u_if.cmd_rdy = 1'b0;
    if (!u_if.cmd_done && n >= ENTRIES * 8 + 40) begin
      clr_cmd_rdy = 1'b1; model_reset();
      @(posedge clk); #1 clr_cmd_rdy = 1'b0;
    end
  endtask

  // Compare process: every response byte, address, register image and completion.
  initial begin
    int a;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!clr_cmd_rdy) begin
        chk("regs", regs, flat());
        chk("addr_in_range", addr_ptr < ENTRIES, 1'b1);
        if (u_if.send_resp) begin
          chk("send_expected", exp_d.size() != 0, 1'b1);
          if (exp_d.size() != 0) begin
            e = exp_d.pop_front();
            a = exp_a.pop_front();
            chk("resp", u_if.resp, e);
            if (a >= 0) chk("addr_ptr", addr_ptr, a);
          end
          got_d.push_back(u_if.resp);
          got_a.push_back(int'(addr_ptr));
        end
        if (u_if.cmd_done) begin
          chk("done_after_resp_sent", prev_rs, 1'b1);
          chk("done_all_bytes_sent", exp_d.size(), 0);
        end
        prev_rs = u_if.resp_sent;
      end else prev_rs = 1'b0;
    end
  end

  // UART transmitter stand-in: acknowledges each byte after a random delay.
  initial begin
    int d;
    u_if.resp_sent = 1'b0;
    forever begin
      @(negedge clk);
      if (u_if.send_resp && !clr_cmd_rdy) begin
        d = $urandom_range(0, 2);
        repeat (d) @(posedge clk);
        @(posedge clk); #1 u_if.resp_sent = 1'b1;
        @(posedge clk); #1 u_if.resp_sent = 1'b0;
      end
    end
  end

  initial begin
    int n, cnt, r;
    logic [15:0] c;
    u_if.cmd = 16'h0000;
    u_if.cmd_rdy = 1'b0;
    for (int ch = 1; ch <= NUM_CH; ch++)
      for (int i = 0; i < ENTRIES; i++) mem[ch][i] = 8'(i) ^ 8'((ch - 1) * 8'h11);
    model_reset();
    #1 clr_cmd_rdy = 1'b1;
    #11;
    chk("rst_resp", u_if.resp, 8'h00);
    chk("rst_send", u_if.send_resp, 1'b0);
    chk("rst_done", u_if.cmd_done, 1'b0);
    chk("rst_addr", addr_ptr, 0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_regs", regs, 0);
    @(posedge clk); #1 clr_cmd_rdy = 1'b0;

    do_cmd(16'h4BAF, 0, 0);
    chk("wr_ack", got_at(0), 8'hA5);
    chk("wr_one_send", got_d.size(), 1);
    chk("wr_reg11", regs[95:88], 8'hAF);
    do_cmd(16'h0B00, 0, 0);
    chk("rd_reg11", got_at(0), 8'hAF);
    do_cmd(16'h5455, 0, 0);
    chk("wr_bad_addr", got_at(0), 8'hEE);
    do_cmd(16'hC000, 0, 0);
    chk("op11", got_at(0), 8'hEE);
    do_cmd(16'h8000, 0, 0);
    chk("dump_ch0", got_at(0), 8'hEE);
    do_cmd(16'h8600, 0, 0);
    chk("dump_ch6", got_at(0), 8'hEE);

    do_cmd(16'h8100, 9'd0, 0);
    chk("dump1_len", got_d.size(), 384);
    chk("dump1_b255", got_at(255), 8'hFF);
    chk("dump1_b256", got_at(256), 8'h00);
    chk("dump1_last", got_at(383), 8'h7F);
    do_cmd(16'h8300, 9'd380, 0);
    chk("dump3_first", got_at(0), 8'h5E);
    chk("dump3_a0", gota_at(0), 380);
    chk("dump3_a4", gota_at(4), 0);
    chk("dump3_alast", gota_at(383), 379);
    do_cmd(16'h8205, 9'd7, 0);
`ifdef CMD_DUMP_LEN_EN
    chk("dump_len5", got_d.size(), 5);
`else
    chk("dump_len_full", got_d.size(), 384);
`endif
    do_cmd(16'h4001, 0, 1);
    chk("cap_and_write", regs[7:0], 8'h21);

    // Abort a dump with reset after ten bytes.
    @(posedge clk);
    #1 u_if.cmd = 16'h8100; ram_addr = 9'd0; u_if.cmd_rdy = 1'b1;
    got_d.delete(); got_a.delete();
    @(posedge clk);
    model_cmd(16'h8100, 9'd0, 1'b0, n);
    n = 0;
    while (got_d.size() < 10 && n < 400) begin @(negedge clk); n++; end
    chk("abort_bytes", got_d.size(), 10);
    #3 clr_cmd_rdy = 1'b1;
    model_reset();
    u_if.cmd_rdy = 1'b0;
    #1;
    chk("abort_resp", u_if.resp, 8'h00);
    chk("abort_send", u_if.send_resp, 1'b0);
    chk("abort_addr", addr_ptr, 0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_regs", regs, 0);
    repeat (2) @(posedge clk);
    #1 clr_cmd_rdy = 1'b0;
    cnt = 0;
    repeat (30) begin @(negedge clk); if (u_if.send_resp) cnt++; end
    chk("abort_no_send", cnt, 0);
    do_cmd(16'h0B00, 0, 0);
    chk("rd_after_abort", got_at(0), 8'h00);

    for (int i = 0; i < 50; i++) begin
      r = $urandom_range(0, 9);
      c[7:0] = 8'($urandom);
      if (r < 4)       c[15:8] = {2'b00, 6'($urandom_range(0, NUM_REGS + 3))};
      else if (r < 8)  c[15:8] = {2'b01, 6'($urandom_range(0, NUM_REGS + 3))};
      else if (r == 8) c[15:8] = ($urandom_range(0, 4) == 0) ? {2'b10, 6'($urandom)}
                                                             : {2'b10, 3'b000, 3'($urandom_range(0, 7))};
      else             c[15:8] = {2'b11, 6'($urandom)};
      do_cmd(c, 9'($urandom_range(0, ENTRIES - 1)), $urandom_range(0, 7) == 0);
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
